// File: rtl/intercal_alu_pkg.sv
// Shared types and constants for the intercal ALU and its byte-serial sequencer.
package intercal_alu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } state_e;

  // Command byte field positions
  localparam int CMD_CHAIN   = 4;
  localparam int CMD_HALF    = 5;
  localparam int CMD_RSV_LSB = 6;
  localparam int CMD_RSV_MSB = 7;

  // Ops 0..7 take both operands, 8..15 are unary on A
  localparam logic [15:0] BINARY_MASK_DEFAULT = 16'h00FF;

  localparam logic [3:0] OP_MINGLE = 4'd0;   // interleave a[15:0] (odd bits) with b[15:0] (even bits)
  localparam logic [3:0] OP_SELECT = 4'd1;   // bits of a where b=1, packed toward bit 0
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_ADD    = 4'd5;
  localparam logic [3:0] OP_SUB    = 4'd6;
  localparam logic [3:0] OP_MUL    = 4'd7;   // low 32 bits of the product
  localparam logic [3:0] OP_UAND   = 4'd8;   // a & ror1(a)
  localparam logic [3:0] OP_UOR    = 4'd9;   // a | ror1(a)
  localparam logic [3:0] OP_UXOR   = 4'd10;  // a ^ ror1(a)
  localparam logic [3:0] OP_NOT    = 4'd11;
  localparam logic [3:0] OP_REV    = 4'd12;  // bit reverse
  localparam logic [3:0] OP_ROL1   = 4'd13;
  localparam logic [3:0] OP_PASS   = 4'd14;
  localparam logic [3:0] OP_NEG    = 4'd15;  // two's complement negate

  function automatic logic op_is_binary(input logic [15:0] mask, input logic [3:0] op);
    return mask[op];
  endfunction

endpackage

// File: rtl/intercal_alu_seq_if.sv
// Command/operand byte stream in, result byte stream out, both valid/ready.
interface intercal_alu_seq_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/intercal_alu.sv
// Purely combinational 16-op ALU over two 32-bit operands.
module intercal_alu
  import intercal_alu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] f
);

  logic [31:0] mingle_v;
  logic [31:0] select_v;
  logic [31:0] rev_v;
  logic [31:0] ror1_v;
  logic [4:0]  sel_pos;

  assign ror1_v = {a[0], a[31:1]};

  // Interleave: a supplies the odd result bits, b the even ones
  always_comb begin
    mingle_v = '0;
    for (int i = 0; i < 16; i++) begin
      mingle_v[2*i+1] = a[i];
      mingle_v[2*i]   = b[i];
    end
  end

  // Gather the bits of a selected by b into the low end of the result
  always_comb begin
    select_v = '0;
    sel_pos  = '0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) begin
        select_v[sel_pos] = a[i];
        sel_pos           = sel_pos + 5'd1;
      end
    end
  end

  // Bit reversal of a
  always_comb begin
    rev_v = '0;
    for (int i = 0; i < 32; i++) rev_v[i] = a[31-i];
  end

  // Op decode
  always_comb begin
    f = '0;
    unique case (op)
      OP_MINGLE: f = mingle_v;
      OP_SELECT: f = select_v;
      OP_AND:    f = a & b;
      OP_OR:     f = a | b;
      OP_XOR:    f = a ^ b;
      OP_ADD:    f = a + b;
      OP_SUB:    f = a - b;
      OP_MUL:    f = a * b;
      OP_UAND:   f = a & ror1_v;
      OP_UOR:    f = a | ror1_v;
      OP_UXOR:   f = a ^ ror1_v;
      OP_NOT:    f = ~a;
      OP_REV:    f = rev_v;
      OP_ROL1:   f = {a[30:0], a[31]};
      OP_PASS:   f = a;
      OP_NEG:    f = -a;
      default:   f = '0;
    endcase
  end

endmodule

// File: rtl/intercal_alu_seq.sv
// Byte-serial command sequencer around one intercal_alu.
//
// state  | meaning
// IDLE   | waiting for a command byte
// LOAD_A | collecting 4 A bytes, LSB first
// LOAD_B | collecting 4 B bytes, LSB first
// EXEC   | one cycle: result register captures the ALU output
// SEND   | streaming 2 or 4 result bytes, LSB first
module intercal_alu_seq
  import intercal_alu_pkg::*;
#(
  parameter logic [15:0] BINARY_MASK = BINARY_MASK_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  intercal_alu_seq_if.slave  bus,
  output logic               busy,
  output logic               err
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q;
  logic [3:0]  op_q;
  logic        half_q;
  logic        err_q;
  logic [31:0] a_q, b_q, res_q;
  logic [31:0] alu_f;

  logic        in_fire, out_fire;
  logic        cmd_ok, cmd_chain;
  logic [3:0]  cmd_op;
  logic [1:0]  last_idx;

  intercal_alu u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .f  (alu_f)
  );

  // Ready/valid derive from state alone, so neither stream sees the other combinationally
  assign bus.in_ready  = (state_q == IDLE) || (state_q == LOAD_A) || (state_q == LOAD_B);
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = (state_q == SEND) ? res_q[{cnt_q, 3'b000} +: 8] : 8'h00;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;

  assign in_fire   = bus.in_valid && bus.in_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;
  assign cmd_ok    = (bus.in_data[CMD_RSV_MSB:CMD_RSV_LSB] == 2'b00);
  assign cmd_chain = bus.in_data[CMD_CHAIN];
  assign cmd_op    = bus.in_data[3:0];
  assign last_idx  = half_q ? 2'd1 : 2'd3;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire && cmd_ok) begin
          if (!cmd_chain)                            state_d = LOAD_A;
          else if (op_is_binary(BINARY_MASK, cmd_op)) state_d = LOAD_B;
          else                                       state_d = EXEC;
        end
      end
      LOAD_A: begin
        if (in_fire && cnt_q == 2'd3)
          state_d = op_is_binary(BINARY_MASK, op_q) ? LOAD_B : EXEC;
      end
      LOAD_B: begin
        if (in_fire && cnt_q == 2'd3) state_d = EXEC;
      end
      EXEC:    state_d = SEND;
      SEND: begin
        if (out_fire && cnt_q == last_idx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command fields, operand capture, result register and byte counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      op_q   <= '0;
      half_q <= 1'b0;
      err_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_fire) begin
            if (!cmd_ok) begin
              err_q <= 1'b1;
            end else begin
              err_q  <= 1'b0;
              op_q   <= cmd_op;
              half_q <= bus.in_data[CMD_HALF];
              cnt_q  <= '0;
              // B is cleared up front so unary ops always see B = 0
              b_q    <= '0;
              if (cmd_chain) a_q <= res_q;
            end
          end
        end
        LOAD_A: begin
          if (in_fire) begin
            a_q[{cnt_q, 3'b000} +: 8] <= bus.in_data;
            cnt_q <= cnt_q + 2'd1;
          end
        end
        LOAD_B: begin
          if (in_fire) begin
            b_q[{cnt_q, 3'b000} +: 8] <= bus.in_data;
            cnt_q <= cnt_q + 2'd1;
          end
        end
        EXEC: begin
          res_q <= alu_f;
          cnt_q <= '0;
        end
        SEND: begin
          if (out_fire) cnt_q <= cnt_q + 2'd1;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule
